// File: rtl/nap_arb_pkg.sv
// Shared types and helpers for the NAP read arbiter.
package nap_arb_pkg;

   typedef enum logic {
      AR_IDLE  = 1'b0,
      AR_ISSUE = 1'b1
   } ar_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   // AXI size code for a full-width beat: log2 of the bus width in bytes.
   function automatic logic [2:0] calc_arsize(input int data_w);
      int bytes;
      calc_arsize = 3'd0;
      bytes = data_w / 8;
      for (int s = 0; s < 8; s++) begin
         if ((1 << s) == bytes) calc_arsize = 3'(s);
      end
   endfunction

endpackage

// File: rtl/nap_read_arbiter_rr.sv
// Round-robin grant: the search starts at ptr and wraps, first request wins.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_vld
);

   // Scan the request vector starting at the priority slot.
   always_comb begin
      int j;
      logic [IDX_W-1:0] jj;
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j  = (int'(ptr) + k) % NUM_REQ;
         jj = IDX_W'(j);
         if (!gnt_vld && req[jj]) begin
            gnt_vld = 1'b1;
            gnt[jj] = 1'b1;
            gnt_idx = jj;
         end
      end
   end

endmodule

// File: rtl/nap_read_arbiter.sv
// Shares one NAP AXI read port between NUM_REQ requesters. AR requests are
// arbitrated round-robin and issued one at a time with ARID = requester index;
// R beats are steered back combinationally by RID.
module nap_read_arbiter
   import nap_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 42,
   parameter int DATA_W    = 256,
   parameter int ID_W      = 8,
   parameter int MAX_OUTST = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [NUM_REQ-1:0]        i_req_arvalid,
   output logic [NUM_REQ-1:0]        o_req_arready,
   input  logic [NUM_REQ*ADDR_W-1:0] i_req_araddr,
   input  logic [NUM_REQ*8-1:0]      i_req_arlen,
   output logic [NUM_REQ-1:0]        o_req_rvalid,
   input  logic [NUM_REQ-1:0]        i_req_rready,
   output logic [DATA_W-1:0]         o_req_rdata,
   output logic [1:0]                o_req_rresp,
   output logic                      o_req_rlast,
   output logic                      o_nap_arvalid,
   input  logic                      i_nap_arready,
   output logic [ADDR_W-1:0]         o_nap_araddr,
   output logic [7:0]                o_nap_arlen,
   output logic [ID_W-1:0]           o_nap_arid,
   output logic [2:0]                o_nap_arsize,
   output logic [1:0]                o_nap_arburst,
   input  logic                      i_nap_rvalid,
   output logic                      o_nap_rready,
   input  logic [DATA_W-1:0]         i_nap_rdata,
   input  logic [1:0]                i_nap_rresp,
   input  logic [ID_W-1:0]           i_nap_rid,
   input  logic                      i_nap_rlast,
   output logic                      o_busy,
   output logic                      o_err_rid
);

   localparam int               IDX_W   = $clog2(NUM_REQ);
   localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

   ar_state_t          state_q, state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [CNT_W-1:0]   cnt_q [NUM_REQ];
   logic [ADDR_W-1:0]  addr_q;
   logic [7:0]         len_q;
   logic [IDX_W-1:0]   id_q;
   logic               err_q;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_vld;
   logic               grant_en;
   logic [ADDR_W-1:0]  sel_addr;
   logic [7:0]         sel_len;

   logic [IDX_W-1:0]   rid_idx;
   logic               rid_hi_zero;
   logic               rid_hit;
   logic               rid_ok;
   logic               sel_rready;
   logic               r_done;
   logic [NUM_REQ-1:0] cnt_nz;

   // A requester may compete only while it has room for another burst.
   always_comb begin
      elig   = '0;
      cnt_nz = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         elig[i]   = i_req_arvalid[i] && (cnt_q[i] < CNT_MAX);
         cnt_nz[i] = (cnt_q[i] != '0);
      end
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .req     (elig),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // AR FSM state register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state_q <= AR_IDLE;
      else         state_q <= state_d;
   end

   // AR FSM next state: grant from IDLE, hold ARVALID in ISSUE until accepted.
   always_comb begin
      state_d       = state_q;
      grant_en      = 1'b0;
      o_nap_arvalid = 1'b0;
      o_req_arready = '0;
      case (state_q)
         AR_IDLE: begin
            if (gnt_vld && !i_reset) begin
               grant_en      = 1'b1;
               o_req_arready = gnt;
               state_d       = AR_ISSUE;
            end
         end
         AR_ISSUE: begin
            o_nap_arvalid = 1'b1;
            if (i_nap_arready) state_d = AR_IDLE;
         end
         default: state_d = AR_IDLE;
      endcase
   end

   // Select the winner's address and length from the flattened request buses.
   always_comb begin
      sel_addr = '0;
      sel_len  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_addr = i_req_araddr[i*ADDR_W +: ADDR_W];
            sel_len  = i_req_arlen[i*8 +: 8];
         end
      end
   end

   // Capture AR fields at grant; the pointer moves one past the winner so the
   // winner has lowest priority next time.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         addr_q <= '0;
         len_q  <= '0;
         id_q   <= '0;
         ptr_q  <= '0;
      end else if (grant_en) begin
         addr_q <= sel_addr;
         len_q  <= sel_len;
         id_q   <= gnt_idx;
         ptr_q  <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   assign o_nap_araddr  = addr_q;
   assign o_nap_arlen   = len_q;
   assign o_nap_arid    = ID_W'(id_q);
   assign o_nap_arsize  = calc_arsize(DATA_W);
   assign o_nap_arburst = AXI_BURST_INCR;

   assign rid_idx = i_nap_rid[IDX_W-1:0];

   if (ID_W > IDX_W) begin : g_rid_hi
      assign rid_hi_zero = ~|i_nap_rid[ID_W-1:IDX_W];
   end else begin : g_rid_nohi
      assign rid_hi_zero = 1'b1;
   end

   // A beat is routable only to an existing requester with a burst in flight;
   // anything else is swallowed so the NAP never deadlocks on a stray ID.
   always_comb begin
      rid_hit      = 1'b0;
      sel_rready   = 1'b0;
      o_req_rvalid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rid_idx == IDX_W'(i)) begin
            rid_hit    = cnt_nz[i];
            sel_rready = i_req_rready[i];
         end
      end
      rid_ok = rid_hi_zero && rid_hit;
      for (int i = 0; i < NUM_REQ; i++) begin
         o_req_rvalid[i] = i_nap_rvalid && rid_ok && (rid_idx == IDX_W'(i));
      end
      o_nap_rready = rid_ok ? sel_rready : 1'b1;
      r_done       = i_nap_rvalid && rid_ok && sel_rready && i_nap_rlast;
   end

   assign o_req_rdata = i_nap_rdata;
   assign o_req_rresp = i_nap_rresp;
   assign o_req_rlast = i_nap_rlast;

   // Outstanding burst counters: up at grant, down at routed RLAST.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({grant_en && gnt[i], r_done && (rid_idx == IDX_W'(i))})
               2'b10:   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
               2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
               default: cnt_q[i] <= cnt_q[i];
            endcase
         end
      end
   end

   // Sticky flag for any beat that could not be routed.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)                      err_q <= 1'b0;
      else if (i_nap_rvalid && !rid_ok) err_q <= 1'b1;
   end

   assign o_err_rid = err_q;
   assign o_busy    = (state_q == AR_ISSUE) || (|cnt_nz);

endmodule

// File: tb/tb_nap_read_arbiter.sv
// Directed bench for nap_read_arbiter with a per-cycle transaction-level model.
module tb_nap_read_arbiter;

   localparam int N      = 4;
   localparam int AW     = 42;
   localparam int DW     = 256;
   localparam int IW     = 8;
   localparam int MAXO   = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    req_arvalid = '0;
   logic [N-1:0]    req_arready;
   logic [N*AW-1:0] req_araddr = '0;
   logic [N*8-1:0]  req_arlen = '0;
   logic [N-1:0]    req_rvalid;
   logic [N-1:0]    req_rready = '1;
   logic [DW-1:0]   req_rdata;
   logic [1:0]      req_rresp;
   logic            req_rlast;
   logic            nap_arvalid;
   logic            nap_arready = 1'b0;
   logic [AW-1:0]   nap_araddr;
   logic [7:0]      nap_arlen;
   logic [IW-1:0]   nap_arid;
   logic [2:0]      nap_arsize;
   logic [1:0]      nap_arburst;
   logic            nap_rvalid = 1'b0;
   logic            nap_rready;
   logic [DW-1:0]   nap_rdata = '0;
   logic [1:0]      nap_rresp = '0;
   logic [IW-1:0]   nap_rid = '0;
   logic            nap_rlast = 1'b0;
   logic            busy;
   logic            err_rid;

   int n_tests = 0;
   int n_fail  = 0;

   nap_read_arbiter #(
      .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTST(MAXO)
   ) dut (
      .i_clk(clk), .i_reset(rst),
      .i_req_arvalid(req_arvalid), .o_req_arready(req_arready),
      .i_req_araddr(req_araddr), .i_req_arlen(req_arlen),
      .o_req_rvalid(req_rvalid), .i_req_rready(req_rready),
      .o_req_rdata(req_rdata), .o_req_rresp(req_rresp), .o_req_rlast(req_rlast),
      .o_nap_arvalid(nap_arvalid), .i_nap_arready(nap_arready),
      .o_nap_araddr(nap_araddr), .o_nap_arlen(nap_arlen), .o_nap_arid(nap_arid),
      .o_nap_arsize(nap_arsize), .o_nap_arburst(nap_arburst),
      .i_nap_rvalid(nap_rvalid), .o_nap_rready(nap_rready),
      .i_nap_rdata(nap_rdata), .i_nap_rresp(nap_rresp), .i_nap_rid(nap_rid),
      .i_nap_rlast(nap_rlast),
      .o_busy(busy), .o_err_rid(err_rid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state: one pending AR, outstanding bursts per requester, priority slot.
   bit          m_pend = 0;
   int          m_id = 0;
   logic [AW-1:0] m_addr = '0;
   logic [7:0]  m_len = '0;
   int          m_cnt [N];
   int          m_next = 0;
   bit          m_err = 0;
   int          gcnt [N];
   int          glog [$];

   initial begin
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0;
         gcnt[i]  = 0;
      end
   end

   // Compare every cycle on the falling edge, then advance the model to the next edge.
   initial forever begin
      int win;
      int rid;
      bit ok;
      logic [N-1:0] exp_ar;
      logic [N-1:0] exp_rv;
      logic         exp_rr;
      bit any_out;
      @(negedge clk);
      if (rst) begin
         m_pend = 0; m_id = 0; m_addr = '0; m_len = '0; m_next = 0; m_err = 0;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end
      win = -1;
      if (!rst && !m_pend) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_next + k) % N;
            if (win < 0 && req_arvalid[j] && m_cnt[j] < MAXO) win = j;
         end
      end
      exp_ar = (win >= 0) ? (N'(1) << win) : '0;
      chk("arready", req_arready, exp_ar);
      chk("arvalid", nap_arvalid, m_pend);
      if (m_pend || rst) begin
         chk("araddr", nap_araddr, m_addr);
         chk("arlen", nap_arlen, m_len);
         chk("arid", nap_arid, m_id);
      end
      rid = int'(nap_rid);
      ok  = (rid < N) && (m_cnt[rid % N] > 0);
      exp_rv = (nap_rvalid && ok) ? (N'(1) << rid) : '0;
      exp_rr = ok ? req_rready[rid % N] : 1'b1;
      chk("rvalid", req_rvalid, exp_rv);
      chk("rready", nap_rready, exp_rr);
      chk("rdata", req_rdata, nap_rdata);
      chk("rresp_rlast", {req_rresp, req_rlast}, {nap_rresp, nap_rlast});
      any_out = 0;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) any_out = 1;
      chk("busy", busy, m_pend || any_out);
      chk("err_rid", err_rid, m_err);
      for (int i = 0; i < N; i++) begin
         if (req_arready[i]) begin
            gcnt[i]++;
            glog.push_back(i);
         end
      end
      if (!rst) begin
         if (win >= 0) begin
            m_pend = 1;
            m_id   = win;
            m_addr = req_araddr[win*AW +: AW];
            m_len  = req_arlen[win*8 +: 8];
            m_cnt[win]++;
            m_next = (win + 1) % N;
         end else if (m_pend && nap_arready) begin
            m_pend = 0;
         end
         if (nap_rvalid && ok && req_rready[rid] && nap_rlast) m_cnt[rid]--;
         if (nap_rvalid && !ok) m_err = 1;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_arvalid = '0;
      nap_rvalid  = 1'b0;
      rst = 1'b1;
      nxt();
      nxt();
      rst = 1'b0;
   endtask

   task automatic beat(input int id, input bit last);
      nap_rvalid = 1'b1;
      nap_rid    = IW'(id);
      nap_rlast  = last;
      nap_rresp  = 2'(id);
      for (int k = 0; k < DW / 32; k++) nap_rdata[k*32 +: 32] = $urandom();
   endtask

   initial begin
      int g0;
      bit seen;
      // Reset state
      @(negedge clk);
      chk("rst_arvalid", nap_arvalid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_araddr", nap_araddr, 0);
      nxt();
      rst = 1'b0;

      // Single requester 0, four-beat burst
      req_araddr[0 +: AW] = AW'(64'h1000);
      req_arlen[0 +: 8]   = 8'd3;
      req_arvalid[0]      = 1'b1;
      nap_arready         = 1'b1;
      @(negedge clk);
      chk("t028_grant", req_arready, 4'b0001);
      chk("t028_no_arvalid_yet", nap_arvalid, 1'b0);
      nxt();
      req_arvalid[0] = 1'b0;
      @(negedge clk);
      chk("t028_arvalid", nap_arvalid, 1'b1);
      chk("t028_arid", nap_arid, 8'd0);
      chk("t028_araddr", nap_araddr, 42'h1000);
      chk("t028_arlen", nap_arlen, 8'd3);
      chk("t028_arsize", nap_arsize, 3'd5);
      chk("t028_arburst", nap_arburst, 2'b01);
      nxt();
      for (int b = 0; b < 4; b++) begin
         beat(0, b == 3);
         @(negedge clk);
         chk("t028_rvalid", req_rvalid, 4'b0001);
         chk("t028_busy", busy, 1'b1);
         nxt();
      end
      nap_rvalid = 1'b0;
      @(negedge clk);
      chk("t028_idle", busy, 1'b0);
      nxt();

      // All four requesters contending
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_araddr[i*AW +: AW] = AW'(64'h100 * (i + 1));
         req_arlen[i*8 +: 8]    = 8'(i);
      end
      glog.delete();
      req_arvalid = '1;
      for (int c = 0; c < 10; c++) nxt();
      req_arvalid = '0;
      nxt();
      chk("t029_ngrants", glog.size(), 5);
      if (glog.size() >= 5) begin
         chk("t029_g0", glog[0], 0);
         chk("t029_g1", glog[1], 1);
         chk("t029_g2", glog[2], 2);
         chk("t029_g3", glog[3], 3);
         chk("t029_g4", glog[4], 0);
      end

      // Requester 2 fills its outstanding budget
      do_reset();
      g0 = gcnt[2];
      req_arvalid[2] = 1'b1;
      for (int c = 0; c < 30; c++) nxt();
      chk("t030_eight", gcnt[2] - g0, 8);
      @(negedge clk);
      chk("t030_blocked", req_arready, 4'b0000);
      nxt();
      beat(2, 1'b1);
      nxt();
      nap_rvalid = 1'b0;
      seen = 0;
      for (int c = 0; c < 6 && !seen; c++) begin
         nxt();
         if (gcnt[2] - g0 == 9) seen = 1;
      end
      chk("t030_ninth", gcnt[2] - g0, 9);
      req_arvalid = '0;
      nxt();

      // Interleaved R for ids 1 and 3, requester 3 back-pressuring
      do_reset();
      req_arlen[1*8 +: 8] = 8'd1;
      req_arlen[3*8 +: 8] = 8'd1;
      req_arvalid[1] = 1'b1;
      nxt();
      req_arvalid[1] = 1'b0;
      nxt();
      req_arvalid[3] = 1'b1;
      nxt();
      req_arvalid[3] = 1'b0;
      nxt();
      req_rready[3] = 1'b0;
      beat(1, 1'b0);
      @(negedge clk);
      chk("t031_r1_pass", {req_rvalid, nap_rready}, {4'b0010, 1'b1});
      nxt();
      beat(3, 1'b0);
      @(negedge clk);
      chk("t031_r3_stall", {req_rvalid, nap_rready}, {4'b1000, 1'b0});
      nxt();
      @(negedge clk);
      chk("t031_r3_stall2", nap_rready, 1'b0);
      nxt();
      beat(1, 1'b1);
      req_rready[1] = 1'b0;
      nxt();
      req_rready[1] = 1'b1;
      @(negedge clk);
      chk("t031_r1_last", {req_rvalid, nap_rready}, {4'b0010, 1'b1});
      nxt();
      req_rready[3] = 1'b1;
      beat(3, 1'b0);
      nxt();
      beat(3, 1'b1);
      nxt();
      nap_rvalid = 1'b0;
      @(negedge clk);
      chk("t031_drained", busy, 1'b0);
      nxt();

      // Out-of-range RID
      beat(5, 1'b1);
      @(negedge clk);
      chk("t032_consume", {req_rvalid, nap_rready}, {4'b0000, 1'b1});
      nxt();
      nap_rvalid = 1'b0;
      @(negedge clk);
      chk("t032_err", err_rid, 1'b1);
      for (int c = 0; c < 4; c++) nxt();
      chk("t032_sticky", err_rid, 1'b1);

      // Reset while an AR is held off by the NAP
      do_reset();
      chk("t033_err_clr", err_rid, 1'b0);
      nap_arready = 1'b0;
      req_arvalid[0] = 1'b1;
      nxt();
      req_arvalid[0] = 1'b0;
      nxt();
      nxt();
      @(negedge clk);
      chk("t033_holding", nap_arvalid, 1'b1);
      nxt();
      rst = 1'b1;
      #1;
      chk("t033_drop_now", nap_arvalid, 1'b0);
      chk("t033_busy_now", busy, 1'b0);
      nxt();
      rst = 1'b0;
      nap_arready = 1'b1;
      @(negedge clk);
      chk("t033_idle", nap_arvalid, 1'b0);
      nxt();
      beat(0, 1'b1);
      @(negedge clk);
      chk("t033_stale_beat", {req_rvalid, nap_rready}, {4'b0000, 1'b1});
      nxt();
      nap_rvalid = 1'b0;
      @(negedge clk);
      chk("t033_stale_err", err_rid, 1'b1);
      nxt();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
